piso_serializer: RTL and testbench

- Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock, with framing strobes.
- It is the sending end for the serial shift-register chain: its sout/sout_valid feed a serial-in receiver.
- A one-entry holding register allows back-to-back words with no idle bit between frames.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_shreg.sv | 35 +++
 rtl/piso_serializer.sv | 126 ++++++++++++
 tb/tb_piso_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
//   state_t : serializer FSM states
//   cnt_w() : bit-counter width for a given word width
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned MIN_WIDTH = 2;

   // Counter indexes bits 0..width-1 and never wraps.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width < MIN_WIDTH) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit loadable shift register feeding the serial output.
//   clk, rst : clock, async active-low reset
//   load     : capture d (has priority over shift)
//   shift    : move one position toward the output end, fill with 0
//   dir      : 1 = output end is bit WIDTH-1 (shift left), 0 = bit 0 (shift right)
//   d        : parallel load value
//   sbit     : current output-end bit
module piso_shreg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   output logic             sbit
);

   logic [WIDTH-1:0] q;

   // Load or shift; vacated positions take 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= dir ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
      end
   end

   assign sbit = dir ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding register so
// consecutive frames are sent without an idle bit between them.
//   clk, rst    : clock, async active-low reset
//   din         : parallel word, taken when load_valid & load_ready
//   load_valid  : din valid
//   load_ready  : holding register empty
//   sout        : serial data bit (0 when no frame bit is present)
//   sout_valid  : sout carries a frame bit
//   frame_start : first bit of a frame
//   frame_done  : last bit of a frame
//   busy        : shifting or a word is held
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   localparam int unsigned    CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] bitcnt, bitcnt_n;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             accept;
   logic             take;
   logic             sh_load;
   logic             sh_shift;
   logic             sh_bit;

   // Accept needs an empty hold and transfer needs a full one, so they never coincide.
   assign accept = load_valid & ~hold_full;

   // Holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= din;
         hold_full <= 1'b1;
      end else if (take) begin
         hold_full <= 1'b0;
      end
   end

   // FSM state and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         bitcnt <= '0;
      end else begin
         state  <= state_n;
         bitcnt <= bitcnt_n;
      end
   end

   // Next state, shifter control and frame strobes.
   always_comb begin
      state_n     = state;
      bitcnt_n    = bitcnt;
      take        = 1'b0;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;
      sout_valid  = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) begin
               take     = 1'b1;
               sh_load  = 1'b1;
               bitcnt_n = '0;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            sout_valid  = 1'b1;
            frame_start = (bitcnt == '0);
            frame_done  = (bitcnt == LAST);
            if (bitcnt != LAST) begin
               sh_shift = 1'b1;
               bitcnt_n = bitcnt + CNT_W'(1);
            end else if (hold_full) begin
               // Chain straight into the next frame.
               take     = 1'b1;
               sh_load  = 1'b1;
               bitcnt_n = '0;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   piso_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (sh_load),
      .shift (sh_shift),
      .dir   (MSB_FIRST),
      .d     (hold),
      .sbit  (sh_bit)
   );

   // The shifter keeps its last bit after a frame ends; mask it outside frames.
   assign sout       = sout_valid & sh_bit;
   assign load_ready = ~hold_full;
   assign busy       = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer instances (W4 MSB-first, W4 LSB-first,
// W2 MSB-first) compared every cycle against a frame-level reference model,
// plus a table of hand-derived vectors and directed corner sequences.
module tb_piso_serializer;

   logic       clk;
   logic       rst;
   logic [3:0] din;
   logic       lv;
   logic [1:0] din2;
   logic       lv2;

   logic ready_a, sout_a, valid_a, fs_a, fd_a, busy_a;
   logic ready_b, sout_b, valid_b, fs_b, fd_b, busy_b;
   logic ready_c, sout_c, valid_c, fs_c, fd_c, busy_c;

   int n_chk  = 0;
   int n_fail = 0;
   int frames_a;
   int valid_cnt;
   int words;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst), .din(din), .load_valid(lv), .load_ready(ready_a),
      .sout(sout_a), .sout_valid(valid_a), .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a));

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .din(din), .load_valid(lv), .load_ready(ready_b),
      .sout(sout_b), .sout_valid(valid_b), .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b));

   piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst), .din(din2), .load_valid(lv2), .load_ready(ready_c),
      .sout(sout_c), .sout_valid(valid_c), .frame_start(fs_c), .frame_done(fd_c), .busy(busy_c));

   // Posedges at 10, 20, ...
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: per instance, the frame being sent (word + bits left)
   // and at most one word waiting.
   int mw   [3] = '{4, 4, 2};
   bit mmsb [3] = '{1'b1, 1'b0, 1'b1};
   int left [3];
   int cur  [3];
   bit pend [3];
   int pword[3];
   bit acc  [3];

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         left[i] = 0; cur[i] = 0; pend[i] = 1'b0; pword[i] = 0; acc[i] = 1'b0;
      end
   endfunction

   function automatic void model_edge(int i, bit v, int d);
      bit was_empty;
      was_empty = !pend[i];
      acc[i] = 1'b0;
      if (left[i] > 1) begin
         left[i] = left[i] - 1;
      end else if (pend[i]) begin
         cur[i]  = pword[i];
         left[i] = mw[i];
         pend[i] = 1'b0;
      end else begin
         left[i] = 0;
      end
      if (v && was_empty) begin
         pend[i]  = 1'b1;
         pword[i] = d;
         acc[i]   = 1'b1;
      end
   endfunction

   // Frame bit k = W-left; MSB-first sends word[W-1-k], LSB-first word[k].
   function automatic logic exp_sout(int i);
      int idx;
      if (left[i] == 0) return 1'b0;
      idx = mmsb[i] ? (left[i] - 1) : (mw[i] - left[i]);
      return 1'((cur[i] >> idx) & 1);
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   function automatic void check_inst(string p, int i, logic s, logic v, logic fs,
                                      logic fd, logic rdy, logic bsy);
      chk({p, ".sout"},        s,   exp_sout(i));
      chk({p, ".sout_valid"},  v,   left[i] > 0);
      chk({p, ".frame_start"}, fs,  left[i] == mw[i]);
      chk({p, ".frame_done"},  fd,  left[i] == 1);
      chk({p, ".load_ready"},  rdy, !pend[i]);
      chk({p, ".busy"},        bsy, (left[i] > 0) || pend[i]);
   endfunction

   function automatic void check_all();
      check_inst("A", 0, sout_a, valid_a, fs_a, fd_a, ready_a, busy_a);
      check_inst("B", 1, sout_b, valid_b, fs_b, fd_b, ready_b, busy_b);
      check_inst("C", 2, sout_c, valid_c, fs_c, fd_c, ready_c, busy_c);
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge(0, lv,  int'(din));
      model_edge(1, lv,  int'(din));
      model_edge(2, lv2, int'(din2));
      #1;
      check_all();
      if (fd_a) frames_a++;
      if (valid_a) valid_cnt++;
   endtask

   typedef struct {
      logic [3:0] din;
      logic       lv;
      logic       sa;
      logic       sb;
      logic       v;
      logic       fs;
      logic       fd;
      logic       rdy;
      logic       bsy;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // Back-to-back 1011 then 0110; expected outputs after each edge.
      //                din      lv  sa  sb  v   fs  fd  rdy bsy
      tbl[0] = '{4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b0; lv = 1'b0; din = '0; lv2 = 1'b0; din2 = '0;
      frames_a = 0; valid_cnt = 0; words = 0;
      model_reset();

      // Reset state, then idle with no load.
      #3;
      check_all();
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // Table: single frames, back-to-back chaining, both bit orders.
      for (int r = 0; r < 10; r++) begin
         din = tbl[r].din;
         lv  = tbl[r].lv;
         step();
         chk($sformatf("tbl[%0d].sout_a", r),      sout_a,  tbl[r].sa);
         chk($sformatf("tbl[%0d].sout_b", r),      sout_b,  tbl[r].sb);
         chk($sformatf("tbl[%0d].sout_valid", r),  valid_a, tbl[r].v);
         chk($sformatf("tbl[%0d].frame_start", r), fs_a,    tbl[r].fs);
         chk($sformatf("tbl[%0d].frame_done", r),  fd_a,    tbl[r].fd);
         chk($sformatf("tbl[%0d].load_ready", r),  ready_a, tbl[r].rdy);
         chk($sformatf("tbl[%0d].busy", r),        busy_a,  tbl[r].bsy);
      end

      // Backpressure: 1111 offered continuously until three words are taken.
      frames_a = 0;
      words    = 0;
      din = 4'b1111;
      lv  = 1'b1;
      for (int c = 0; c < 40 && words < 3; c++) begin
         step();
         if (acc[0]) words++;
      end
      lv = 1'b0;
      for (int c = 0; c < 12; c++) step();
      chk("bp.words_accepted", words, 3);
      chk("bp.frames_sent", frames_a, 3);

      // Reset mid-frame with a word held.
      din = 4'b1011; lv = 1'b1;
      step();                       // accept
      din = 4'b0110;
      step();                       // transfer, bit 0 out
      step();                       // accept 0110, bit 1 out
      lv = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("mid_rst.sout_valid", valid_a, 1'b0);
      chk("mid_rst.load_ready", ready_a, 1'b1);
      chk("mid_rst.busy",       busy_a,  1'b0);
      #2 rst = 1'b1;
      valid_cnt = 0;
      for (int c = 0; c < 8; c++) step();
      chk("mid_rst.residual_bits", valid_cnt, 0);

      // WIDTH=2 continuous stream: hold refills one cycle after each transfer.
      lv2 = 1'b1; din2 = 2'($urandom);
      for (int c = 0; c < 20; c++) begin
         step();
         if (acc[2]) din2 = 2'($urandom);
         if (c >= 2) chk("w2.stream_valid", valid_c, 1'b1);
      end
      lv2 = 1'b0;
      for (int c = 0; c < 4; c++) step();

      // Randomized traffic; the source holds din while not accepted.
      for (int c = 0; c < 800; c++) begin
         if (!lv || acc[0]) begin
            lv  = 1'($urandom_range(0, 1));
            din = 4'($urandom);
         end
         if (!lv2 || acc[2]) begin
            lv2  = 1'($urandom_range(0, 1));
            din2 = 2'($urandom);
         end
         step();
      end
      lv = 1'b0; lv2 = 1'b0;
      for (int c = 0; c < 10; c++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
